// File: rtl/dmem_responder.sv
// ============================================================================
// Module  : dmem_responder
// Brief   : Word-organised data memory behind a valid/ready request/response
//           pair, with a programmable wait-state delay and a debug read port.
// Revision: 1.0
// ============================================================================
`default_nettype none

module dmem_responder #(
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                  SYS_clk,
  input  logic                  SYS_reset,
  input  logic                  REQ_valid,
  output logic                  REQ_ready,
  input  logic                  REQ_write,
  input  logic [31:0]           REQ_address,
  input  logic [31:0]           REQ_wdata,
  output logic                  RSP_valid,
  input  logic                  RSP_ready,
  output logic [31:0]           RSP_rdata,
  output logic                  RSP_error,
  input  logic [ADDR_WIDTH-1:0] DBG_address,
  output logic [31:0]           DBG_data
);

  localparam int unsigned DEPTH     = 2 ** ADDR_WIDTH;
  localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_CYCLES);

  generate
    if (WAIT_CYCLES > 15) begin : g_wait_range_check
      $error("dmem_responder: WAIT_CYCLES must be in 0..15");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    wr_q, wr_d;
  logic [31:0]             addr_q, addr_d;
  logic [31:0]             wdata_q, wdata_d;
  logic [31:0]             rdata_q, rdata_d;
  logic                    err_q, err_d;
  logic [31:0]             mem_q [DEPTH];

  logic                    acc_write;
  logic [31:0]             acc_addr;
  logic [31:0]             acc_wdata;
  logic                    acc_err;
  logic [ADDR_WIDTH-1:0]   acc_idx;
  logic                    do_access;
  logic                    mem_we;

  // With zero wait states the access happens on the acceptance edge itself,
  // so the access operands come straight from the request port in IDLE.
  always_comb begin
    acc_write = (state_q == ST_IDLE) ? REQ_write   : wr_q;
    acc_addr  = (state_q == ST_IDLE) ? REQ_address : addr_q;
    acc_wdata = (state_q == ST_IDLE) ? REQ_wdata   : wdata_q;
    acc_err   = (acc_addr[1:0] != 2'b00) ||
                ((acc_addr >> (ADDR_WIDTH + 2)) != 32'd0);
    acc_idx   = acc_addr[ADDR_WIDTH+1:2];
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    do_access = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (REQ_valid) begin
          wr_d    = REQ_write;
          addr_d  = REQ_address;
          wdata_d = REQ_wdata;
          if (WAIT_CYCLES == 0) begin
            do_access = 1'b1;
            state_d   = ST_RESP;
          end else begin
            cnt_d   = WAIT_LOAD;
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          do_access = 1'b1;
          state_d   = ST_RESP;
        end
      end
      ST_RESP: begin
        if (RSP_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (do_access) begin
      err_d   = acc_err;
      rdata_d = (acc_err || acc_write) ? 32'd0 : mem_q[acc_idx];
    end
  end

  assign mem_we = do_access && acc_write && !acc_err;

  always_ff @(posedge SYS_clk or posedge SYS_reset) begin
    if (SYS_reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      wr_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // The array is deliberately not reset; reset forces IDLE asynchronously,
  // which suppresses any store that had not yet reached its performing edge.
  always_ff @(posedge SYS_clk) begin
    if (mem_we) begin
      mem_q[acc_idx] <= acc_wdata;
    end
  end

  assign REQ_ready = (state_q == ST_IDLE);
  assign RSP_valid = (state_q == ST_RESP);
  assign RSP_rdata = rdata_q;
  assign RSP_error = err_q;
  assign DBG_data  = mem_q[DBG_address];

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
// ============================================================================
// Module  : tb_dmem_responder
// Brief   : Scoreboard bench for dmem_responder (WAIT_CYCLES=2 and =0 copies).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        SYS_reset;
  int          cyc = 0;
  int          n_vec = 0;
  int          n_mis = 0;

  logic        REQ_valid2, REQ_ready2, REQ_write2, RSP_valid2, RSP_ready2, RSP_error2;
  logic [31:0] REQ_address2, REQ_wdata2, RSP_rdata2, DBG_data2;
  logic [7:0]  DBG_address2;

  logic        REQ_valid0, REQ_ready0, REQ_write0, RSP_valid0, RSP_ready0, RSP_error0;
  logic [31:0] REQ_address0, REQ_wdata0, RSP_rdata0, DBG_data0;
  logic [7:0]  DBG_address0;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          acc;
  } exp_t;

  exp_t q2[$];
  exp_t q0[$];

  dmem_responder #(.ADDR_WIDTH(8), .WAIT_CYCLES(2)) u_dut2 (
    .SYS_clk(clk), .SYS_reset(SYS_reset),
    .REQ_valid(REQ_valid2), .REQ_ready(REQ_ready2), .REQ_write(REQ_write2),
    .REQ_address(REQ_address2), .REQ_wdata(REQ_wdata2),
    .RSP_valid(RSP_valid2), .RSP_ready(RSP_ready2), .RSP_rdata(RSP_rdata2),
    .RSP_error(RSP_error2), .DBG_address(DBG_address2), .DBG_data(DBG_data2)
  );

  dmem_responder #(.ADDR_WIDTH(8), .WAIT_CYCLES(0)) u_dut0 (
    .SYS_clk(clk), .SYS_reset(SYS_reset),
    .REQ_valid(REQ_valid0), .REQ_ready(REQ_ready0), .REQ_write(REQ_write0),
    .REQ_address(REQ_address0), .REQ_wdata(REQ_wdata0),
    .RSP_valid(RSP_valid0), .RSP_ready(RSP_ready0), .RSP_rdata(RSP_rdata0),
    .RSP_error(RSP_error0), .DBG_address(DBG_address0), .DBG_data(DBG_data0)
  );

  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail(input string nm);
    n_vec++;
    n_mis++;
    $display("FAIL %s: event missing or unexpected (cycle %0d)", nm, cyc);
  endtask

  // Response monitors: latency checked on the first valid cycle, data on handshake.
  initial begin
    bit   seen = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (SYS_reset) seen = 0;
      else begin
        if (RSP_valid2 && !seen) begin
          seen = 1;
          if (q2.size() == 0) fail("rsp2_unexpected");
          else check("rsp2_latency", 32'(cyc - q2[0].acc), 32'd2);
        end
        if (RSP_valid2 && RSP_ready2) begin
          seen = 0;
          if (q2.size() != 0) begin
            e = q2.pop_front();
            check("rsp2_rdata", RSP_rdata2, e.rd);
            check("rsp2_error", 32'(RSP_error2), 32'(e.err));
          end
        end
      end
    end
  end

  initial begin
    bit   seen = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (SYS_reset) seen = 0;
      else begin
        if (RSP_valid0 && !seen) begin
          seen = 1;
          if (q0.size() == 0) fail("rsp0_unexpected");
          else check("rsp0_latency", 32'(cyc - q0[0].acc), 32'd0);
        end
        if (RSP_valid0 && RSP_ready0) begin
          seen = 0;
          if (q0.size() != 0) begin
            e = q0.pop_front();
            check("rsp0_rdata", RSP_rdata0, e.rd);
            check("rsp0_error", 32'(RSP_error0), 32'(e.err));
          end
        end
      end
    end
  end

  // Called at posedge+1 with the WAIT_CYCLES=2 instance idle; returns at
  // acceptance edge +1 with request fields scrambled.
  task automatic req2(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                      input logic [31:0] ex_rd, input logic ex_err);
    exp_t e;
    REQ_valid2 = 1'b1;
    REQ_write2 = wr;
    REQ_address2 = addr;
    REQ_wdata2 = wd;
    @(negedge clk);
    check("req2_ready", 32'(REQ_ready2), 32'd1);
    e.rd = ex_rd;
    e.err = ex_err;
    e.acc = cyc + 1;
    q2.push_back(e);
    @(posedge clk);
    #1;
    REQ_valid2 = 1'b0;
    REQ_write2 = 1'($urandom);
    REQ_address2 = $urandom;
    REQ_wdata2 = $urandom;
  endtask

  task automatic wait_done2;
    int n = 0;
    while (q2.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    if (q2.size() != 0) begin
      fail("rsp2_timeout");
      q2.delete();
    end
    #1;
  endtask

  task automatic wait_valid2;
    int n = 0;
    @(negedge clk);
    while (!RSP_valid2 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!RSP_valid2) fail("rsp2_valid_timeout");
  endtask

  initial begin
    int acc[3];
    int n;
    SYS_reset = 1'b1;
    REQ_valid2 = 0; REQ_write2 = 0; REQ_address2 = 0; REQ_wdata2 = 0;
    RSP_ready2 = 1; DBG_address2 = 0;
    REQ_valid0 = 0; REQ_write0 = 0; REQ_address0 = 0; REQ_wdata0 = 0;
    RSP_ready0 = 1; DBG_address0 = 0;
    #2;
    check("reset_req_ready", 32'(REQ_ready2), 32'd1);
    check("reset_rsp_valid", 32'(RSP_valid2), 32'd0);
    check("reset_rsp_rdata", RSP_rdata2, 32'd0);
    check("reset_rsp_error", 32'(RSP_error2), 32'd0);
    check("reset0_req_ready", 32'(REQ_ready0), 32'd1);
    check("reset0_rsp_valid", 32'(RSP_valid0), 32'd0);
    repeat (2) @(posedge clk);
    #3 SYS_reset = 1'b0;
    @(posedge clk);
    #1;

    // Store then load.
    req2(1'b1, 32'h10, 32'hDEADBEEF, 32'd0, 1'b0);
    wait_done2();
    DBG_address2 = 8'd4;
    #1 check("dbg_word4", DBG_data2, 32'hDEADBEEF);
    req2(1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
    wait_done2();

    // Error cases leave the array unchanged.
    req2(1'b1, 32'h4, 32'h00000004, 32'd0, 1'b0);
    wait_done2();
    req2(1'b0, 32'h12, 32'h0, 32'd0, 1'b1);
    wait_done2();
    req2(1'b0, 32'h400, 32'h0, 32'd0, 1'b1);
    wait_done2();
    req2(1'b1, 32'h404, 32'h00000BAD, 32'd0, 1'b1);
    wait_done2();
    DBG_address2 = 8'd1;
    #1 check("dbg_word1_after_err", DBG_data2, 32'h00000004);
    DBG_address2 = 8'd4;
    #1 check("dbg_word4_after_err", DBG_data2, 32'hDEADBEEF);

    // Response back-pressure with a competing request.
    RSP_ready2 = 1'b0;
    req2(1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
    wait_valid2();
    REQ_valid2 = 1'b1; REQ_write2 = 1'b1; REQ_address2 = 32'h10; REQ_wdata2 = 32'h0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_valid", 32'(RSP_valid2), 32'd1);
      check("stall_rdata", RSP_rdata2, 32'hDEADBEEF);
      check("stall_req_ready", 32'(REQ_ready2), 32'd0);
    end
    @(posedge clk);
    #1;
    REQ_valid2 = 1'b0;
    RSP_ready2 = 1'b1;
    @(posedge clk);
    #1;
    check("stall_release_idle", 32'(REQ_ready2), 32'd1);
    check("stall_release_valid", 32'(RSP_valid2), 32'd0);
    check("stall_no_store", DBG_data2, 32'hDEADBEEF);
    if (q2.size() != 0) begin
      fail("stall_rsp_missing");
      q2.delete();
    end

    // Zero wait states, back-to-back stores.
    REQ_valid0 = 1'b1; REQ_write0 = 1'b1;
    REQ_address0 = 32'h0; REQ_wdata0 = 32'hA0A0A0A0;
    for (int i = 0; i < 3; i++) begin
      exp_t e;
      n = 0;
      @(negedge clk);
      while (!REQ_ready0 && n < 10) begin
        @(negedge clk);
        n++;
      end
      if (!REQ_ready0) fail("b2b_ready_timeout");
      acc[i] = cyc + 1;
      e.rd = 32'd0; e.err = 1'b0; e.acc = cyc + 1;
      q0.push_back(e);
      @(posedge clk);
      #1;
      REQ_address0 = 32'((i + 1) * 4);
      REQ_wdata0 = 32'hA0A0A0A0 + 32'(i + 1);
      if (i == 2) REQ_valid0 = 1'b0;
    end
    check("b2b_gap01", 32'(acc[1] - acc[0]), 32'd2);
    check("b2b_gap12", 32'(acc[2] - acc[1]), 32'd2);
    repeat (3) @(posedge clk);
    #1;
    if (q0.size() != 0) begin
      fail("b2b_rsp_missing");
      q0.delete();
    end
    DBG_address0 = 8'd0;
    #1 check("b2b_word0", DBG_data0, 32'hA0A0A0A0);
    DBG_address0 = 8'd1;
    #1 check("b2b_word1", DBG_data0, 32'hA0A0A0A1);
    DBG_address0 = 8'd2;
    #1 check("b2b_word2", DBG_data0, 32'hA0A0A0A2);
    @(posedge clk);
    #1;

    // Reset during WAIT discards the store.
    req2(1'b1, 32'h20, 32'h11111111, 32'd0, 1'b0);
    wait_done2();
    req2(1'b1, 32'h20, 32'h12345678, 32'd0, 1'b0);
    #3 SYS_reset = 1'b1;
    #1;
    check("rst_wait_valid", 32'(RSP_valid2), 32'd0);
    check("rst_wait_ready", 32'(REQ_ready2), 32'd1);
    q2.delete();
    @(negedge clk);
    SYS_reset = 1'b0;
    @(posedge clk);
    #1;
    DBG_address2 = 8'd8;
    #1 check("rst_wait_dbg", DBG_data2, 32'h11111111);
    req2(1'b0, 32'h20, 32'h0, 32'h11111111, 1'b0);
    wait_done2();

    // Reset during RESP keeps the committed store.
    RSP_ready2 = 1'b0;
    req2(1'b1, 32'h20, 32'hCAFEF00D, 32'd0, 1'b0);
    wait_valid2();
    #2 SYS_reset = 1'b1;
    #1 check("rst_resp_valid", 32'(RSP_valid2), 32'd0);
    q2.delete();
    @(negedge clk);
    SYS_reset = 1'b0;
    RSP_ready2 = 1'b1;
    @(posedge clk);
    #1;
    req2(1'b0, 32'h20, 32'h0, 32'hCAFEF00D, 1'b0);
    wait_done2();

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

`default_nettype wire
